// File: rtl/cordic_iter_sequencer.sv
// Sequencer for one iterative CORDIC operation: load pulse, shift-index stepping
// 0..N_ITER-1, and one extra micro-iteration for each odd index flagged in rep_en.
module cordic_iter_sequencer #(
  parameter int N_ITER = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       rep_en,
  input  logic             abort,
  input  logic             step_ready,
  output logic             busy,
  output logic             load,
  output logic             iter_valid,
  output logic [IDX_W-1:0] iter_idx,
  output logic             is_repeat,
  output logic             done,
  output logic [IDX_W:0]   step_cnt,
  output logic [2:0]       state_dbg
);

  // Step handshake: a step is presented while iter_valid=1 and transfers on any
  // cycle where step_ready=1; iter_idx/is_repeat hold until that cycle.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_REP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ITER - 1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);

  state_t           state_q, state_d;
  logic [5:0]       rep_q, rep_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             load_q, load_d;
  logic             valid_q, valid_d;
  logic             is_rep_q, is_rep_d;
  logic             done_q, done_d;
  logic             rep_hit;
  logic             last_idx;

  always_comb begin
    // Flag k selects index 2k+1; flags pointing past the last index never match.
    rep_hit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if ((2 * k + 1) < N_ITER && idx_q == IDX_W'(2 * k + 1)) begin
        rep_hit = rep_q[k];
      end
    end
    last_idx = (idx_q == IDX_LAST);
  end

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          rep_d   = rep_en;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_LOAD: state_d = S_ITER;
      S_ITER: begin
        if (step_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          if (rep_hit) begin
            state_d = S_REP;
          end else if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_REP: begin
        if (step_ready) begin
          cnt_d = cnt_q + CNT_ONE;
          if (last_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_ITER;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over a same-cycle step acceptance; counters keep their values.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
    end

    busy_d   = (state_d == S_LOAD) || (state_d == S_ITER) || (state_d == S_REP);
    load_d   = (state_d == S_LOAD);
    valid_d  = (state_d == S_ITER) || (state_d == S_REP);
    is_rep_d = (state_d == S_REP);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rep_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      valid_q  <= 1'b0;
      is_rep_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rep_q    <= rep_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      load_q   <= load_d;
      valid_q  <= valid_d;
      is_rep_q <= is_rep_d;
      done_q   <= done_d;
    end
  end

  assign busy       = busy_q;
  assign load       = load_q;
  assign iter_valid = valid_q;
  assign iter_idx   = idx_q;
  assign is_repeat  = is_rep_q;
  assign done       = done_q;
  assign step_cnt   = cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Bench for cordic_iter_sequencer: a step-list model checked against the DUT every
// cycle, plus hand-computed latency and count expectations for each directed test.
module tb_cordic_iter_sequencer;

  localparam int N_ITER = 16;
  localparam int IDX_W  = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort, step_ready;
  logic [5:0]       rep_en;
  logic             busy, load, iter_valid, is_repeat, done;
  logic [IDX_W-1:0] iter_idx;
  logic [IDX_W:0]   step_cnt;
  logic [2:0]       state_dbg;

  cordic_iter_sequencer #(.N_ITER(N_ITER), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rep_en(rep_en), .abort(abort),
    .step_ready(step_ready), .busy(busy), .load(load), .iter_valid(iter_valid),
    .iter_idx(iter_idx), .is_repeat(is_repeat), .done(done), .step_cnt(step_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic tog = 1'b0;

  // ---------------- model: an operation is a list of steps ----------------
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             rep;
  } step_t;

  step_t m_steps[$];
  int m_phase = 0;  // 0 idle, 1 load, 2 stepping, 3 done
  int m_pos   = 0;
  int m_cnt   = 0;
  int m_idx   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_idx = 0; m_pos = 0;
      m_steps.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
          step_t s;
          m_steps.delete();
          for (int i = 0; i < N_ITER; i++) begin
            s.idx = IDX_W'(i); s.rep = 1'b0;
            m_steps.push_back(s);
            if ((i % 2) == 1 && (i / 2) < 6 && rep_en[i / 2]) begin
              s.rep = 1'b1;
              m_steps.push_back(s);
            end
          end
          m_pos = 0; m_cnt = 0; m_idx = 0; m_phase = 1;
        end
        1: m_phase = abort ? 0 : 2;
        2: begin
          if (abort) m_phase = 0;
          else if (step_ready) begin
            m_cnt++; m_pos++;
            if (m_pos == m_steps.size()) m_phase = 3;
            else m_idx = int'(m_steps[m_pos].idx);
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  int op_start = 0, op_done = 0, op_done_cyc = 0, op_steps = 0, op_reps = 0;

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",       32'(busy),       32'(m_phase == 1 || m_phase == 2));
      chk("load",       32'(load),       32'(m_phase == 1));
      chk("iter_valid", 32'(iter_valid), 32'(m_phase == 2));
      chk("is_repeat",  32'(is_repeat),  32'(m_phase == 2 && m_steps[m_pos].rep));
      chk("done",       32'(done),       32'(m_phase == 3));
      chk("iter_idx",   32'(iter_idx),   32'(m_idx));
      chk("step_cnt",   32'(step_cnt),   32'(m_cnt));
      if (done === 1'b1) begin
        op_done++;
        op_done_cyc = cyc;
      end
      if (iter_valid === 1'b1 && step_ready && !abort && !rst) begin
        op_steps++;
        if (is_repeat === 1'b1) op_reps++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (tog) step_ready = ~step_ready;
  endtask

  task automatic start_op(input logic [5:0] r, input logic rdy0, input logic t);
    rep_en = r; start = 1'b1; step_ready = rdy0; tog = t;
    op_start = cyc; op_done = 0; op_steps = 0; op_reps = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_phase != 0 && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(m_phase != 0), 32'd0);
    tog = 1'b0; step_ready = 1'b1;
    repeat (2) step();
  endtask

  task automatic run_plain(input string tag);
    start_op(6'b000000, 1'b1, 1'b0);
    wait_idle(200);
    chk({tag, "_done_lat"}, 32'(op_done_cyc - op_start), 32'd18);
    chk({tag, "_done_cnt"}, 32'(op_done), 32'd1);
    chk({tag, "_steps"},    32'(step_cnt), 32'd16);
    chk({tag, "_reps"},     32'(op_reps), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; start = 1'b0; rep_en = '0; abort = 1'b0; step_ready = 1'b1;
    step();
    chk_en = 1'b1;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt",  32'(step_cnt), 32'd0);
    rst = 1'b0;
    step();

    // T1: no repeats, step_ready held high.
    run_plain("t1");

    // T2: all six repeats.
    start_op(6'b111111, 1'b1, 1'b0);
    chk("t2_model_len", 32'(m_steps.size()), 32'd22);
    wait_idle(200);
    chk("t2_done_lat", 32'(op_done_cyc - op_start), 32'd24);
    chk("t2_steps",    32'(step_cnt), 32'd22);
    chk("t2_reps",     32'(op_reps), 32'd6);

    // T3: idx 1 and 5 repeated, step_ready alternating (low on first step cycle).
    start_op(6'b000101, 1'b0, 1'b1);
    wait_idle(200);
    chk("t3_done_lat", 32'(op_done_cyc - op_start), 32'd38);
    chk("t3_steps",    32'(step_cnt), 32'd18);
    chk("t3_reps",     32'(op_reps), 32'd2);

    // T4: start + rep_en change at c5, start again during DONE: both ignored.
    start_op(6'b000000, 1'b1, 1'b0);
    repeat (4) step();
    start = 1'b1; rep_en = 6'b111111;
    step();
    start = 1'b0;
    while (cyc < op_start + 18) step();
    chk("t4_in_done", 32'(done), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(200);
    repeat (4) step();
    chk("t4_done_cnt", 32'(op_done), 32'd1);
    chk("t4_steps",    32'(step_cnt), 32'd16);
    chk("t4_reps",     32'(op_reps), 32'd0);
    chk("t4_busy",     32'(busy), 32'd0);

    // T5: abort at c6 with idx 1 repeated.
    start_op(6'b000001, 1'b1, 1'b0);
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_busy",  32'(busy), 32'd0);
    chk("t5_valid", 32'(iter_valid), 32'd0);
    chk("t5_cnt",   32'(step_cnt), 32'd4);
    repeat (4) step();
    chk("t5_no_done", 32'(op_done), 32'd0);
    chk("t5_cnt_hold", 32'(step_cnt), 32'd4);
    run_plain("t5_after");

    // T6: reset while presenting the repeat of idx 1.
    start_op(6'b000001, 1'b1, 1'b0);
    repeat (3) step();
    chk("t6_in_rep", 32'(is_repeat), 32'd1);
    rst = 1'b1;
    step();
    chk("t6_busy",  32'(busy), 32'd0);
    chk("t6_valid", 32'(iter_valid), 32'd0);
    chk("t6_rep",   32'(is_repeat), 32'd0);
    chk("t6_idx",   32'(iter_idx), 32'd0);
    chk("t6_cnt",   32'(step_cnt), 32'd0);
    rst = 1'b0;
    step();
    run_plain("t6_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
